// File: rtl/sevenseg_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package sevenseg_pkg;

  localparam int DIGIT_W               = 4;
  localparam int DEFAULT_PERIOD_CYCLES = 24000;
  localparam int DEFAULT_BLANK_CYCLES  = 240;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Slot prescaler: counts clk cycles within one digit slot and flags the last blank
// cycle, the cycle before the last one, and the last cycle of the slot.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int BLANK_CYCLES  = DEFAULT_BLANK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic blank_end_o,
  output logic slot_end_o,
  output logic slot_last_next_o
);

  localparam int CNT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_PREV  = CNT_W'(PERIOD_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign blank_end_o      = (cnt_q == BLANK_LAST);
  assign slot_end_o       = (cnt_q == SLOT_LAST);
  assign slot_last_next_o = (cnt_q == SLOT_PREV);
  assign cnt_d            = slot_end_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Round-robin seven-segment digit scanner with blanking gaps and a frame-aligned
// double-buffered display value. Define SEVSEG_LZB_EN for leading-zero blanking.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int BLANK_CYCLES  = DEFAULT_BLANK_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic [NUM_DIGITS-1:0]         en_n,
  output logic [DIGIT_W-1:0]            nibble,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sevenseg_scan_ctrl: NUM_DIGITS must be in 2..8");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PERIOD_CYCLES) begin : g_bad_blank
    $error("sevenseg_scan_ctrl: need 1 <= BLANK_CYCLES < PERIOD_CYCLES");
  end

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  digit_vec_t            shadow_q, shadow_d, staged_q;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
  logic [DIGIT_W-1:0]    nibble_q, nibble_d;
  logic                  frame_done_q, frame_done_d;
  logic                  blank_end, slot_end, slot_last_next;
  logic                  transfer, frame_end, digit_lit;

  sevenseg_slot_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk             (clk),
    .reset           (reset),
    .blank_end_o     (blank_end),
    .slot_end_o      (slot_end),
    .slot_last_next_o(slot_last_next)
  );

  assign load_ready = ~pending_q;
  assign transfer   = load_valid & load_ready;
  assign frame_end  = slot_end & (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      BLANK: if (blank_end) state_d = SHOW;
      SHOW: begin
        if (slot_end) begin
          state_d = BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

  // A load accepted on the frame_done cycle only sets pending; it commits a frame later.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      shadow_d  = staged_q;
      pending_d = 1'b0;
    end
    if (transfer) pending_d = 1'b1;
  end

  // Outputs are registered from next-state so they line up with the slot phase.
  always_comb begin
`ifdef SEVSEG_LZB_EN
    digit_lit = (idx_d == '0) || ((shadow_q >> (DIGIT_W * int'(idx_d))) != '0);
`else
    digit_lit = 1'b1;
`endif
    en_n_d   = '1;
    nibble_d = nibble_q;
    if (state_d == SHOW) begin
      nibble_d = shadow_q[idx_d];
      if (digit_lit) en_n_d[idx_d] = 1'b0;
    end
    frame_done_d = (state_d == SHOW) && (idx_d == LAST_IDX) && slot_last_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      en_n_q       <= '1;
      nibble_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      en_n_q       <= en_n_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: staged is read only while pending is set and reset clears pending, so it carries no reset.
  always_ff @(posedge clk) begin
    if (transfer) staged_q <= digits_in;
  end

  assign en_n       = en_n_q;
  assign nibble     = nibble_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared seven-segment cathode bus. It cycles digit enables round-robin from a prescaled slot timer and inserts a blanking interval between digits to suppress ghosting. It presents the active digit's nibble to the downstream hex-to-segment decoder. New display values arrive over a valid/ready handshake and are double-buffered so that they apply only at frame boundaries.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (2..8)
PERIOD_CYCLES, 24000, clk cycles per digit slot (1 kHz per digit at 24 MHz)
BLANK_CYCLES, 240, cycles at the start of each slot with all digits off; elaboration error unless 1 <= BLANK_CYCLES < PERIOD_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits_in  in  4*NUM_DIGITS  staged display value; digit k = digits_in[4k+3:4k], digit 0 = least significant
load_valid  in  1  digits_in valid
load_ready  out  1  block can accept a load
en_n  out  NUM_DIGITS  active-low digit enables
nibble  out  4  value for the enabled digit, fed to decoder
frame_done  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (sync, active-high): the clock edge with reset=1 forces en_n=all 1s, nibble=0, frame_done=0, digit index=0, slot counter=0, state=BLANK, shadow=0, pending=0. load_ready=1 from the first cycle after reset. Reset mid-slot or mid-load aborts everything; the staged value is dropped.
- Reset clock and polarity: one clock, clk; reset is synchronous and active-high.
- Registered outputs: en_n, nibble and frame_done are all registered.
- Slot timing, as observed at the outputs:
  - Each slot is PERIOD_CYCLES cycles long.
  - The first BLANK_CYCLES cycles of a slot have en_n all 1s (BLANK).
  - The remaining PERIOD_CYCLES-BLANK_CYCLES cycles have en_n[idx]=0, all other bits 1, and nibble=shadow[idx] (SHOW).
  - The first slot after reset is digit 0, BLANK.
- FSM: BLANK -> SHOW when cnt==BLANK_CYCLES-1. SHOW -> BLANK when cnt==PERIOD_CYCLES-1; at that point cnt is cleared and idx advances (NUM_DIGITS-1 wraps to 0).
- At most one en_n bit is low in any cycle. The enable never changes directly from one digit to another.
- nibble is held at its last value during BLANK.
- frame_done=1 exactly on the last SHOW cycle of digit NUM_DIGITS-1.
- Handshake:
  - load_ready = ~pending.
  - A transfer occurs when load_valid && load_ready on a rising edge; digits_in is captured into staged and pending is set.
  - load_valid without ready is ignored; the source must hold it.
- Frame commit:
  - On the frame_done cycle, if pending=1, shadow <= staged and pending <= 0. load_ready reasserts on the following cycle.
  - The new value is first visible at digit 0 SHOW of the next frame.
- Simultaneous events: a transfer accepted on the frame_done cycle while pending=0 is not committed that frame. It commits at the next frame_done.

Optional Feature:
SEVSEG_LZB_EN
- Defined: leading-zero blanking. During SHOW, en_n[k] stays 1 if digit k and all higher digits of shadow are 0, for k>0. Digit 0 is always shown. Slot timing is unchanged (the blanked slot stays dark).
- Undefined: all digits are shown.

Decomposition:
- Package sevenseg_pkg holds:
  - the scan_state_t enum (BLANK, SHOW)
  - the default PERIOD_CYCLES and BLANK_CYCLES constants
  - the DIGIT_W=4 constant
- One sub-module, sevenseg_slot_timer. It owns the prescale counter and produces the blank_end and slot_end ticks.
- The FSM, handshake and buffers stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=2, PERIOD_CYCLES=8, BLANK_CYCLES=2.
1. Reset held 3 cycles, then released -> en_n=2'b11, nibble=0, frame_done=0 during reset; load_ready=1 on the first post-reset cycle. The first 2 cycles have en_n=11, then 6 cycles en_n=10.
2. Load 8'h3A, then run 2 frames -> after the commit, each 16-cycle frame shows:
   - 2 cycles en_n=11
   - 6 cycles en_n=10 with nibble=A
   - 2 cycles en_n=11
   - 6 cycles en_n=01 with nibble=3
   - frame_done high only on cycle 16.
3. Load 8'h12 accepted, then load_valid held with 8'h34 -> load_ready=0 until the cycle after frame_done. 8'h34 is accepted then and is displayed one frame after 8'h12.
4. Reset asserted during digit 1 SHOW with a load pending -> en_n=11 after the edge; restart at digit 0 with nibble=0. The pending value is never displayed.
5. Load accepted exactly on the frame_done cycle -> the old value is displayed for the whole next frame; the new value appears the frame after.
6. Shadow 8'h05 -> with SEVSEG_LZB_EN, digit 1 slot keeps en_n=11 throughout and digit 0 shows 5. Without the macro, digit 1 shows nibble=0. Shadow 8'h00 with the macro -> digit 0 still shows 0.
